// File: rtl/spi_out_sequencer.sv
// Saturates signed samples to BITS-wide words, queues them in a two-deep FIFO and
// hands them one at a time to an SPI output master, optionally refreshing the last word.
module spi_out_sequencer #(
  parameter int IN_BITS = 16,
  parameter int BITS    = 8,
  parameter int REFRESH = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IN_BITS-1:0] val_in,
  input  logic               val_valid,
  output logic               val_ready,
  input  logic               spi_cs,
  output logic [BITS-1:0]    tx_data,
  output logic               tx_start,
  output logic               busy
);

  localparam int RMAX = (REFRESH > 0) ? (REFRESH - 1) : 0;
  localparam int RW   = (RMAX > 0) ? $clog2(RMAX + 1) : 1;
  localparam logic [RW-1:0]   RMAX_V     = RW'(RMAX);
  localparam logic [RW-1:0]   RONE       = RW'(1);
  localparam logic            REFRESH_EN = (REFRESH != 0) ? 1'b1 : 1'b0;
  localparam logic [BITS-1:0] WORD_MAX   = {BITS{1'b1}};
  localparam logic [BITS-1:0] WORD_ZERO  = {BITS{1'b0}};
  localparam logic [1:0]      TO_LAST    = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_LOW  = 2'd2,
    WAIT_HIGH = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [BITS-1:0] fifo_q [2];
  logic [BITS-1:0] fifo_d [2];
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      count_q, count_d;
  logic [BITS-1:0] tx_data_q, tx_data_d;
  logic [BITS-1:0] last_word_q, last_word_d;
  logic            tx_start_q, tx_start_d;
  logic            busy_q, busy_d;
  logic            sent_once_q, sent_once_d;
  logic [RW-1:0]   refresh_cnt_q, refresh_cnt_d;
  logic [1:0]      timeout_q, timeout_d;
  logic            push_s;
  logic            pop_s;
  logic            refresh_hit_s;

  // Negative samples clamp to zero, anything above the word range clamps to all-ones.
  function automatic logic [BITS-1:0] saturate(input logic [IN_BITS-1:0] v);
    logic [BITS-1:0] r;
    if (v[IN_BITS-1]) begin
      r = WORD_ZERO;
    end else if ((v >> BITS) != {IN_BITS{1'b0}}) begin
      r = WORD_MAX;
    end else begin
      r = v[BITS-1:0];
    end
    return r;
  endfunction

  assign val_ready     = (count_q != 2'd2);
  assign push_s        = val_valid & val_ready;
  assign pop_s         = (state_q == IDLE) & spi_cs & (count_q != 2'd0);
  assign refresh_hit_s = REFRESH_EN & sent_once_q & spi_cs & (state_q == IDLE)
                         & (count_q == 2'd0) & (refresh_cnt_q == RMAX_V);

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign busy     = busy_q;

  // Next-state, FIFO bookkeeping and registered-output computation.
  always_comb begin
    state_d       = state_q;
    fifo_d        = fifo_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    tx_data_d     = tx_data_q;
    last_word_d   = last_word_q;
    sent_once_d   = sent_once_q;
    refresh_cnt_d = refresh_cnt_q;
    timeout_d     = timeout_q;

    case (state_q)
      IDLE: begin
        if (pop_s) begin
          tx_data_d   = fifo_q[rd_ptr_q];
          last_word_d = fifo_q[rd_ptr_q];
          state_d     = START;
        end else if (refresh_hit_s) begin
          tx_data_d = last_word_q;
          state_d   = START;
        end else begin
          state_d = IDLE;
        end
        if ((count_q == 2'd0) && (refresh_cnt_q != RMAX_V)) begin
          refresh_cnt_d = refresh_cnt_q + RONE;
        end else begin
          refresh_cnt_d = refresh_cnt_q;
        end
      end
      START: begin
        sent_once_d   = 1'b1;
        refresh_cnt_d = {RW{1'b0}};
        timeout_d     = 2'd0;
        state_d       = WAIT_LOW;
      end
      WAIT_LOW: begin
        // A master that never drops chip-select must not wedge the sequencer.
        if (!spi_cs) begin
          state_d = WAIT_HIGH;
        end else if (timeout_q == TO_LAST) begin
          state_d = IDLE;
        end else begin
          timeout_d = timeout_q + 2'd1;
        end
      end
      WAIT_HIGH: begin
        if (spi_cs) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_HIGH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (push_s) begin
      fifo_d[wr_ptr_q] = saturate(val_in);
      wr_ptr_d         = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    tx_start_d = (state_d == START);
    busy_d     = (state_d != IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      fifo_q[0]     <= WORD_ZERO;
      fifo_q[1]     <= WORD_ZERO;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      tx_data_q     <= WORD_ZERO;
      last_word_q   <= WORD_ZERO;
      tx_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      sent_once_q   <= 1'b0;
      refresh_cnt_q <= {RW{1'b0}};
      timeout_q     <= 2'd0;
    end else begin
      state_q       <= state_d;
      fifo_q        <= fifo_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      tx_data_q     <= tx_data_d;
      last_word_q   <= last_word_d;
      tx_start_q    <= tx_start_d;
      busy_q        <= busy_d;
      sent_once_q   <= sent_once_d;
      refresh_cnt_q <= refresh_cnt_d;
      timeout_q     <= timeout_d;
    end
  end

endmodule

// File: tb/tb_spi_out_sequencer.sv
// Directed + randomized bench for spi_out_sequencer against a transaction-level
// reference model (word queue, phase and idle counters) kept in the bench.
module tb_spi_out_sequencer;

  localparam int REFRESH = 20;
  localparam int P_IDLE = 0, P_START = 1, P_WLOW = 2, P_WHIGH = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] val_in;
  logic        val_valid;
  logic        val_ready;
  logic        spi_cs;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        busy;

  spi_out_sequencer #(.IN_BITS(16), .BITS(8), .REFRESH(REFRESH)) dut (
    .clk(clk), .reset(reset), .val_in(val_in), .val_valid(val_valid),
    .val_ready(val_ready), .spi_cs(spi_cs), .tx_data(tx_data),
    .tx_start(tx_start), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int mq[$];
  int m_phase = P_IDLE, m_wl = 0, m_idle = 0, m_cur = 0, m_last = 0;
  bit m_sent = 1'b0, pushed = 1'b0;
  int dut_log[$], gap_log[$], start_tick[$];
  int cyc = 0, idle_run = 0;
  bit master_on = 1'b0, glitch_on = 1'b0;
  int cs_left = 0, bit_len = 8;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input logic [15:0] v);
    int s;
    s = int'($signed(v));
    if (s < 0) return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  // One clock: advance the model on the current inputs, then compare and drive the master.
  task automatic tick();
    int sz;
    bit ready_pre;
    ready_pre = (mq.size() != 2);
    pushed = 1'b0;
    if (reset) begin
      mq.delete();
      m_phase = P_IDLE; m_wl = 0; m_idle = 0; m_cur = 0; m_last = 0; m_sent = 1'b0;
    end else begin
      sz = mq.size();
      case (m_phase)
        P_IDLE: begin
          if (spi_cs && sz > 0) begin
            m_cur = mq.pop_front(); m_last = m_cur; m_phase = P_START;
          end else if (spi_cs && sz == 0 && m_sent && m_idle == REFRESH - 1) begin
            m_cur = m_last; m_phase = P_START;
          end
          if (sz == 0 && m_idle < REFRESH - 1) m_idle++;
        end
        P_START: begin
          m_sent = 1'b1; m_idle = 0; m_wl = 0; m_phase = P_WLOW;
        end
        P_WLOW: begin
          if (!spi_cs) m_phase = P_WHIGH;
          else begin
            m_wl++;
            if (m_wl == 4) m_phase = P_IDLE;
          end
        end
        default: begin
          if (spi_cs) m_phase = P_IDLE;
        end
      endcase
      if (val_valid && ready_pre) begin
        mq.push_back(sat(val_in));
        pushed = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("tx_start", tx_start, (m_phase == P_START));
    chk("busy", busy, (m_phase != P_IDLE));
    chk("tx_data", tx_data, m_cur);
    chk("val_ready", val_ready, (mq.size() != 2));
    if (tx_start === 1'b1) begin
      dut_log.push_back(int'(tx_data));
      gap_log.push_back(idle_run);
      start_tick.push_back(cyc);
    end
    if (busy === 1'b0) idle_run++;
    else idle_run = 0;
    cyc++;
    if (master_on) begin
      if (cs_left > 0) begin
        cs_left--;
        if (cs_left == 0) spi_cs = 1'b1;
      end else if (tx_start === 1'b1) begin
        spi_cs = 1'b0; cs_left = bit_len;
      end else if (glitch_on && $urandom_range(0, 15) == 0) begin
        spi_cs = 1'b0; cs_left = $urandom_range(1, 3);
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic push_word(input logic [15:0] v);
    bit done;
    done = 1'b0;
    val_valid = 1'b1;
    val_in = v;
    for (int i = 0; i < 60 && !done; i++) begin
      tick();
      if (pushed) done = 1'b1;
    end
    val_valid = 1'b0;
    chk("push_accepted", done, 1);
  endtask

  task automatic wait_start();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      if (tx_start === 1'b1) seen = 1'b1;
    end
    chk("start_seen", seen, 1);
  endtask

  task automatic wait_idle();
    bit seen;
    seen = (busy === 1'b0);
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      if (busy === 1'b0) seen = 1'b1;
    end
    chk("idle_seen", seen, 1);
  endtask

  initial begin
    int base;
    int n;
    reset = 1'b1; val_valid = 1'b0; val_in = 16'h0000; spi_cs = 1'b1;
    run(3);
    reset = 1'b0;
    tick();
    chk("ready_after_reset", val_ready, 1);

    // No send yet: idle time must not trigger a refresh.
    base = dut_log.size();
    run(3 * REFRESH);
    chk("no_refresh_before_send", dut_log.size() - base, 0);

    // Single word, held stable for the whole transfer.
    master_on = 1'b1;
    base = dut_log.size();
    push_word(16'h0042);
    wait_start();
    chk("single_word", tx_data, 8'h42);
    for (int i = 0; i < 40 && busy === 1'b1; i++) begin
      tick();
      chk("tx_data_hold", tx_data, 8'h42);
    end
    chk("busy_after_transfer", busy, 0);
    chk("single_pulse", dut_log.size() - base, 1);

    // Saturation: negative, over-range, in-range boundary.
    base = dut_log.size();
    push_word(16'hFFFB);
    push_word(16'h0300);
    push_word(16'h00FF);
    run(30);
    chk("sat_count", dut_log.size() - base, 3);
    chk("sat_neg", dut_log[base], 8'h00);
    chk("sat_over", dut_log[base + 1], 8'hFF);
    chk("sat_edge", dut_log[base + 2], 8'hFF);

    // Back-pressure while a transfer is in flight.
    base = dut_log.size();
    push_word(16'h0010);
    wait_start();
    push_word(16'h0020);
    push_word(16'h0030);
    chk("ready_full", val_ready, 0);
    push_word(16'h0040);
    run(40);
    chk("bp_count", dut_log.size() - base, 4);
    for (int i = 0; i < 4; i++) chk("bp_order", dut_log[base + i], 16 * (i + 1));

    // Refresh of the last word after REFRESH idle cycles.
    base = dut_log.size();
    push_word(16'h005A);
    run(80);
    n = dut_log.size() - base;
    chk("refresh_seen", (n >= 3), 1);
    chk("refresh_first", dut_log[base], 8'h5A);
    for (int i = base + 1; i < dut_log.size(); i++) begin
      chk("refresh_data", dut_log[i], 8'h5A);
      chk("refresh_gap", gap_log[i], REFRESH);
    end

    // Master never answers: WAIT_LOW timeout, then the next queued word starts.
    wait_idle();
    master_on = 1'b0;
    spi_cs = 1'b1;
    base = dut_log.size();
    push_word(16'h0011);
    push_word(16'h0022);
    run(20);
    chk("timeout_first", dut_log[base], 8'h11);
    chk("timeout_second", dut_log[base + 1], 8'h22);
    chk("timeout_spacing", start_tick[base + 1] - start_tick[base], 6);

    // Reset during WAIT_HIGH with a full FIFO.
    master_on = 1'b1;
    wait_idle();
    push_word(16'h0061);
    wait_start();
    push_word(16'h0062);
    push_word(16'h0063);
    chk("full_before_reset", val_ready, 0);
    tick();
    chk("in_wait_high", busy, 1);
    reset = 1'b1;
    tick();
    chk("rst_tx_start", tx_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_ready", val_ready, 1);
    tick();
    reset = 1'b0;
    base = dut_log.size();
    run(2 * REFRESH);
    chk("no_start_after_reset", dut_log.size() - base, 0);

    // Randomized traffic with variable transfer lengths and chip-select glitches.
    glitch_on = 1'b1;
    for (int i = 0; i < 500; i++) begin
      bit_len = $urandom_range(1, 10);
      val_valid = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 2))
        0: val_in = 16'($urandom_range(0, 255));
        1: val_in = 16'h8000 | 16'($urandom());
        default: val_in = 16'($urandom());
      endcase
      tick();
    end
    val_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_out_sequencer.md
SPI_OUT_SEQUENCER -- requirements
Module: spi_out_sequencer

Interface
REQ-001 The block SHALL have parameter IN_BITS, default 16, meaning width of the signed input sample.
REQ-002 The block SHALL have parameter BITS, default 8, meaning width of the word handed to the SPI output master.
REQ-003 The block SHALL have parameter REFRESH, default 1000, meaning the idle-cycle count before the last word is retransmitted; 0 disables refresh.
REQ-004 The block SHALL have port clk  input  1  clock; all logic is on the rising edge.
REQ-005 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port val_in  input  IN_BITS  signed two's-complement sample.
REQ-007 The block SHALL have port val_valid  input  1  val_in is valid this cycle.
REQ-008 The block SHALL have port val_ready  output  1  the block accepts val_in this cycle.
REQ-009 The block SHALL have port spi_cs  input  1  chip-select from the SPI output master: 1 = idle, 0 = transfer in progress.
REQ-010 The block SHALL have port tx_data  output  BITS  word presented to the master, in true (non-inverted) polarity.
REQ-011 The block SHALL have port tx_start  output  1  single-cycle request to the master to start a transfer.
REQ-012 The block SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 Saturation SHALL be applied on acceptance: val_in < 0 -> 0; val_in > 2^BITS-1 -> 2^BITS-1; otherwise val_in[BITS-1:0].
REQ-014 Saturated words SHALL be stored in a 2-entry FIFO with a 2-bit occupancy count of 0..2.
REQ-015 val_ready SHALL equal (count != 2), derived from registered state only, with no combinational path from spi_cs or val_valid.
REQ-016 A push SHALL occur when val_valid && val_ready; a push while full SHALL be impossible, since val_ready is 0.
REQ-017 A push and a pop in the same cycle SHALL leave count unchanged and preserve FIFO order.
REQ-018 The FSM SHALL have the states IDLE, START, WAIT_LOW and WAIT_HIGH.
REQ-019 In IDLE with count > 0 and spi_cs == 1, the block SHALL pop the head into tx_data and last_word, assert tx_start for the next cycle, and go to START.
REQ-020 In IDLE with count == 0, spi_cs == 1, REFRESH != 0, sent_once == 1 and refresh_cnt == REFRESH-1, the block SHALL load last_word into tx_data, assert tx_start and go to START.
REQ-021 In IDLE with spi_cs == 0, the block SHALL not start a transfer.
REQ-022 START SHALL last exactly one cycle with tx_start == 1, then go to WAIT_LOW; tx_start SHALL be 0 in every other state.
REQ-023 WAIT_LOW SHALL go to WAIT_HIGH when spi_cs == 0.
REQ-024 WAIT_LOW SHALL return to IDLE if spi_cs stays 1 for 4 consecutive cycles (timeout), without re-queuing the word.
REQ-025 WAIT_HIGH SHALL go to IDLE when spi_cs == 1.
REQ-026 tx_data SHALL be held constant from START until WAIT_HIGH exits, because the master samples it on every bit.
REQ-027 sent_once SHALL be set on the first START after reset.
REQ-028 refresh_cnt SHALL increment only in IDLE with count == 0, saturate at REFRESH-1, and clear on every START.
REQ-029 A FIFO word SHALL take priority over a refresh in the same cycle.
REQ-030 Back-to-back words SHALL be separated by at least one IDLE cycle.

Reset
REQ-031 On reset the block SHALL set state = IDLE, tx_start = 0, tx_data = 0, busy = 0, count = 0, last_word = 0, sent_once = 0 and refresh_cnt = 0; val_ready SHALL be 1 in the cycle after reset deasserts.
REQ-032 Reset asserted mid-transfer SHALL discard the FIFO contents and the in-flight word, with no tx_start pulse while reset is high.

Verification
REQ-033 Bench: push val_in = 0x0042 with the master model idle -> one tx_start pulse, tx_data = 0x42 stable until spi_cs returns high, then busy = 0.
REQ-034 Bench: push -5, then 0x0300, then 0x00FF -> transmitted words 0x00, 0xFF, 0xFF, in that order.
REQ-035 Bench: push 3 words while a transfer is in flight -> val_ready = 0 after the 2nd, the 3rd is held until a pop, all 3 are delivered in order.
REQ-036 Bench: REFRESH = 20, send 0x5A, then no input -> 0x5A is retransmitted every time 20 idle cycles elapse after spi_cs returns high; with no prior send, no refresh occurs.
REQ-037 Bench: hold spi_cs = 1 after tx_start -> FSM returns to IDLE after the 4-cycle timeout and the next FIFO word then starts.
REQ-038 Bench: assert reset during WAIT_HIGH with 2 words queued -> all outputs reach reset values, count = 0, and no further tx_start occurs until a new push.
